// File: rtl/vend_pkg.sv
// Shared definitions for the coin-change vending datapath: coin values, ejector
// select encodings and the payout FSM state set.
package vend_pkg;

  localparam logic [6:0] CoinNickel  = 7'd5;
  localparam logic [6:0] CoinDime    = 7'd10;
  localparam logic [6:0] CoinQuarter = 7'd25;
  localparam logic [6:0] MaxAmt      = 7'd95;

  localparam logic [1:0] SelNone    = 2'b00;
  localparam logic [1:0] SelNickel  = 2'b01;
  localparam logic [1:0] SelDime    = 2'b10;
  localparam logic [1:0] SelQuarter = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StEject,
    StGap,
    StDone,
    StFault
  } vend_state_e;

  function automatic logic [6:0] coin_value(input logic [1:0] sel);
    logic [6:0] val;
    case (sel)
      SelNickel:  val = CoinNickel;
      SelDime:    val = CoinDime;
      SelQuarter: val = CoinQuarter;
      default:    val = 7'd0;
    endcase
    return val;
  endfunction

  function automatic logic amt_valid(input logic [6:0] amt);
    return (amt <= MaxAmt) && ((amt % 7'd5) == 7'd0);
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Three 4-bit coin tube counters: load on reset, fill to 15 on refill, and
// decrement the selected tube by one coin.
module coin_inventory
  import vend_pkg::*;
#(
  parameter int unsigned INV_INIT = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_refill,
  input  logic       i_dec,
  input  logic [1:0] i_sel,
  output logic [3:0] o_inv_q,
  output logic [3:0] o_inv_d,
  output logic [3:0] o_inv_n
);

  localparam logic [3:0] InitCnt = 4'(INV_INIT);
  localparam logic [3:0] FullCnt = 4'd15;

  logic [3:0] r_inv_q;
  logic [3:0] r_inv_d;
  logic [3:0] r_inv_n;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inv_q <= InitCnt;
      r_inv_d <= InitCnt;
      r_inv_n <= InitCnt;
    end else if (i_refill) begin
      r_inv_q <= FullCnt;
      r_inv_d <= FullCnt;
      r_inv_n <= FullCnt;
    end else if (i_dec) begin
      // Empty tubes hold at zero even if a decrement were ever requested.
      unique case (i_sel)
        SelQuarter: if (r_inv_q != 4'd0) r_inv_q <= r_inv_q - 4'd1;
        SelDime:    if (r_inv_d != 4'd0) r_inv_d <= r_inv_d - 4'd1;
        SelNickel:  if (r_inv_n != 4'd0) r_inv_n <= r_inv_n - 4'd1;
        default:    ;
      endcase
    end
  end

  assign o_inv_q = r_inv_q;
  assign o_inv_d = r_inv_d;
  assign o_inv_n = r_inv_n;

endmodule

// File: rtl/change_dispenser_ctrl.sv
// Greedy change payout controller: picks Q/D/N one coin at a time, drives the
// ejector handshake with an ack timeout, and tracks tube inventory.
module change_dispenser_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned INV_INIT    = 8,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] change_amt,
  input  logic       refill,
  output logic       eject_req,
  output logic [1:0] eject_sel,
  input  logic       eject_ack,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic       err,
  output logic       fault,
  output logic [6:0] remaining,
  output logic [3:0] inv_q,
  output logic [3:0] inv_d,
  output logic [3:0] inv_n
);

  localparam logic [7:0] TmoLast = 8'(ACK_TIMEOUT - 1);

  vend_state_e r_state;
  vend_state_e w_state_nxt;
  logic [6:0]  r_rem;
  logic [6:0]  w_rem_nxt;
  logic [1:0]  r_sel;
  logic [1:0]  w_sel_nxt;
  logic        r_short;
  logic        w_short_nxt;
  logic        r_err;
  logic        w_err_nxt;
  logic [7:0]  r_tmo;
  logic [7:0]  w_tmo_nxt;
  logic        w_refill;
  logic        w_dec;
  logic [1:0]  w_pick_sel;

  coin_inventory #(
    .INV_INIT(INV_INIT)
  ) u_inv (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_refill(w_refill),
    .i_dec   (w_dec),
    .i_sel   (r_sel),
    .o_inv_q (inv_q),
    .o_inv_d (inv_d),
    .o_inv_n (inv_n)
  );

  // Largest coin that fits the amount owed and is still in stock.
  always_comb begin
    w_pick_sel = SelNone;
    if ((r_rem >= CoinQuarter) && (inv_q != 4'd0)) begin
      w_pick_sel = SelQuarter;
    end else if ((r_rem >= CoinDime) && (inv_d != 4'd0)) begin
      w_pick_sel = SelDime;
    end else if ((r_rem >= CoinNickel) && (inv_n != 4'd0)) begin
      w_pick_sel = SelNickel;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_sel_nxt   = r_sel;
    w_short_nxt = r_short;
    w_err_nxt   = 1'b0;
    w_tmo_nxt   = r_tmo;
    w_refill    = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      StIdle: begin
        if (start) begin
          if (amt_valid(change_amt)) begin
            w_rem_nxt   = change_amt;
            w_short_nxt = 1'b0;
            w_state_nxt = StSelect;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (refill) begin
          w_refill = 1'b1;
        end
      end
      StSelect: begin
        if (r_rem == 7'd0) begin
          w_state_nxt = StDone;
        end else if (w_pick_sel != SelNone) begin
          w_sel_nxt   = w_pick_sel;
          w_tmo_nxt   = 8'd0;
          w_state_nxt = StEject;
        end else begin
          w_short_nxt = 1'b1;
          w_state_nxt = StDone;
        end
      end
      StEject: begin
        if (eject_ack) begin
          w_dec       = 1'b1;
          w_rem_nxt   = r_rem - coin_value(r_sel);
          w_state_nxt = StGap;
        end else if (r_tmo == TmoLast) begin
          w_state_nxt = StFault;
        end else begin
          w_tmo_nxt = r_tmo + 8'd1;
        end
      end
      StGap:   w_state_nxt = StSelect;
      StDone:  w_state_nxt = StIdle;
      StFault: w_state_nxt = StFault;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_rem   <= 7'd0;
      r_sel   <= SelNone;
      r_short <= 1'b0;
      r_err   <= 1'b0;
      r_tmo   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_sel   <= w_sel_nxt;
      r_short <= w_short_nxt;
      r_err   <= w_err_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  assign eject_req = (r_state == StEject);
  assign eject_sel = eject_req ? r_sel : SelNone;
  assign busy      = (r_state != StIdle) && (r_state != StFault);
  assign done      = (r_state == StDone);
  assign fault     = (r_state == StFault);
  assign short     = r_short;
  assign err       = r_err;
  assign remaining = r_rem;

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Scoreboard bench: directed payouts push expected events; a negedge monitor
// pops and compares ejects, done pulses, err pulses and fault entry.
module tb_change_dispenser_ctrl;
  import vend_pkg::*;

  localparam int KEject = 0;
  localparam int KDone  = 1;
  localparam int KErr   = 2;
  localparam int KFault = 3;

  typedef struct {
    int d;
    int kind;
    int sel;
    int sh;
    int rem;
    int inv;
    int off;
  } ev_t;

  logic clk;
  logic rst;
  logic start0, refill0, ack0;
  logic [6:0] amt0;
  logic req0, busy0, done0, short0, err0, fault0;
  logic [1:0] sel0;
  logic [6:0] rem0;
  logic [3:0] iq0, id0, in0;
  logic start1, refill1, ack1;
  logic [6:0] amt1;
  logic req1, busy1, done1, short1, err1, fault1;
  logic [1:0] sel1;
  logic [6:0] rem1;
  logic [3:0] iq1, id1, in1;

  int n_checks = 0;
  int n_errs = 0;
  int cyc = 0;
  ev_t sb[$];
  int start_cyc[2];
  int last_fall[2];
  bit first_pend[2];
  bit prev_req[2];
  bit prev_flt[2];
  int hold_sel[2];
  bit ack_en[2];

  change_dispenser_ctrl dut0 (
    .clk(clk), .rst(rst), .start(start0), .change_amt(amt0), .refill(refill0),
    .eject_req(req0), .eject_sel(sel0), .eject_ack(ack0), .busy(busy0), .done(done0),
    .short(short0), .err(err0), .fault(fault0), .remaining(rem0),
    .inv_q(iq0), .inv_d(id0), .inv_n(in0)
  );

  change_dispenser_ctrl #(.INV_INIT(1), .ACK_TIMEOUT(15)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .change_amt(amt1), .refill(refill1),
    .eject_req(req1), .eject_sel(sel1), .eject_ack(ack1), .busy(busy1), .done(done1),
    .short(short1), .err(err1), .fault(fault1), .remaining(rem1),
    .inv_q(iq1), .inv_d(id1), .inv_n(in1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic int inv3(input int q, input int d, input int n);
    return q * 256 + d * 16 + n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input int kind, input int sel, input int sh, input int rem,
                      input int inv, input int off);
    ev_t e;
    e.d = d; e.kind = kind; e.sel = sel; e.sh = sh; e.rem = rem; e.inv = inv; e.off = off;
    sb.push_back(e);
  endtask

  task automatic take(input int d, input int kind, output ev_t e, output bit ok);
    ok = 1'b0;
    e = '{default: 0};
    if (sb.size() == 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL unexpected_event: dut%0d kind %0d seen, expected none", d, kind);
    end else begin
      e = sb.pop_front();
      chk("event_order", d * 10 + kind, e.d * 10 + e.kind);
      ok = (e.d == d) && (e.kind == kind);
    end
  endtask

  task automatic mon(input int d, input logic req, input logic [1:0] sel, input logic dn,
                     input logic sh, input logic [6:0] rem, input logic [3:0] iq,
                     input logic [3:0] idd, input logic [3:0] inn, input logic er,
                     input logic flt);
    ev_t e;
    bit ok;
    if (req && !prev_req[d]) begin
      take(d, KEject, e, ok);
      if (ok) chk("eject_sel", int'(sel), e.sel);
      if (first_pend[d]) begin
        chk("first_eject_lat", cyc - start_cyc[d], 2);
        first_pend[d] = 1'b0;
      end else begin
        chk("gap_len", cyc - last_fall[d], 2);
      end
      hold_sel[d] = int'(sel);
    end else if (req) begin
      chk("sel_stable", int'(sel), hold_sel[d]);
    end
    if (!req && prev_req[d]) last_fall[d] = cyc;
    if (dn) begin
      take(d, KDone, e, ok);
      if (ok) begin
        chk("done_short", int'(sh), e.sh);
        chk("done_remaining", int'(rem), e.rem);
        chk("done_tubes", int'({iq, idd, inn}), e.inv);
        if (e.off >= 0) chk("done_lat", cyc - start_cyc[d], e.off);
      end
    end
    if (er) begin
      take(d, KErr, e, ok);
      if (ok) chk("err_lat", cyc - start_cyc[d], e.off);
    end
    if (flt && !prev_flt[d]) begin
      take(d, KFault, e, ok);
      if (ok) chk("fault_lat", cyc - start_cyc[d], e.off);
    end
    prev_req[d] = req;
    prev_flt[d] = flt;
  endtask

  initial forever begin
    @(negedge clk);
    mon(0, req0, sel0, done0, short0, rem0, iq0, id0, in0, err0, fault0);
    mon(1, req1, sel1, done1, short1, rem1, iq1, id1, in1, err1, fault1);
  end

  // Ejector model: acknowledge on the first eject_req cycle when enabled.
  initial begin
    ack0 = 1'b0;
    forever begin
      @(negedge clk);
      if (ack0) ack0 = 1'b0;
      else if (req0 && ack_en[0]) ack0 = 1'b1;
    end
  end

  initial begin
    ack1 = 1'b0;
    forever begin
      @(negedge clk);
      if (ack1) ack1 = 1'b0;
      else if (req1 && ack_en[1]) ack1 = 1'b1;
    end
  end

  task automatic pay(input int d, input int amt, input bit with_refill);
    @(posedge clk);
    #1;
    if (d == 0) begin
      start0 = 1'b1; amt0 = 7'(amt); refill0 = with_refill;
    end else begin
      start1 = 1'b1; amt1 = 7'(amt); refill1 = with_refill;
    end
    start_cyc[d] = cyc;
    first_pend[d] = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0; refill0 = 1'b0;
    start1 = 1'b0; refill1 = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget);
    bit b;
    b = 1'b1;
    for (int n = 0; n < budget && b; n++) begin
      @(negedge clk);
      b = (d == 0) ? busy0 : busy1;
    end
    chk("idle_reached", int'(b), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    start0 = 1'b0; refill0 = 1'b0; amt0 = '0;
    start1 = 1'b0; refill1 = 1'b0; amt1 = '0;
    ack_en[0] = 1'b1;
    ack_en[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_eject_req", int'(req0), 0);
    chk("rst_eject_sel", int'(sel0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_short", int'(short0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_fault", int'(fault0), 0);
    chk("rst_remaining", int'(rem0), 0);
    chk("rst_tubes0", int'({iq0, id0, in0}), inv3(8, 8, 8));
    chk("rst_tubes1", int'({iq1, id1, in1}), inv3(1, 1, 1));

    @(posedge clk);
    #1 refill0 = 1'b1;
    @(posedge clk);
    #1 refill0 = 1'b0;
    @(negedge clk);
    chk("refill_tubes", int'({iq0, id0, in0}), inv3(15, 15, 15));

    push(0, KEject, 3, 0, 0, 0, -1);
    push(0, KEject, 2, 0, 0, 0, -1);
    push(0, KEject, 1, 0, 0, 0, -1);
    push(0, KDone, 0, 0, 0, inv3(14, 14, 14), -1);
    pay(0, 40, 1'b0);
    wait_idle(0, 60);
    idle(3);

    push(0, KDone, 0, 0, 0, inv3(14, 14, 14), 2);
    pay(0, 0, 1'b0);
    wait_idle(0, 20);
    idle(3);

    push(0, KErr, 0, 0, 0, 0, 1);
    pay(0, 37, 1'b0);
    idle(2);
    chk("err37_busy", int'(busy0), 0);
    push(0, KErr, 0, 0, 0, 0, 1);
    pay(0, 100, 1'b0);
    idle(2);
    chk("err100_busy", int'(busy0), 0);

    // start and refill together: refill must be dropped
    push(0, KEject, 3, 0, 0, 0, -1);
    push(0, KEject, 3, 0, 0, 0, -1);
    push(0, KEject, 3, 0, 0, 0, -1);
    push(0, KEject, 2, 0, 0, 0, -1);
    push(0, KEject, 2, 0, 0, 0, -1);
    push(0, KDone, 0, 0, 0, inv3(11, 12, 14), -1);
    pay(0, 95, 1'b1);
    wait_idle(0, 80);
    idle(3);

    push(1, KEject, 3, 0, 0, 0, -1);
    push(1, KEject, 2, 0, 0, 0, -1);
    push(1, KEject, 1, 0, 0, 0, -1);
    push(1, KDone, 0, 1, 20, inv3(0, 0, 0), -1);
    pay(1, 60, 1'b0);
    wait_idle(1, 60);
    idle(3);
    chk("short_held", int'(short1), 1);
    chk("short_remaining", int'(rem1), 20);

    push(1, KDone, 0, 0, 0, inv3(0, 0, 0), 2);
    pay(1, 0, 1'b0);
    wait_idle(1, 20);
    idle(3);

    ack_en[0] = 1'b0;
    push(0, KEject, 3, 0, 0, 0, -1);
    push(0, KFault, 0, 0, 0, 0, 17);
    pay(0, 25, 1'b0);
    wait_idle(0, 40);
    idle(1);
    chk("fault_set", int'(fault0), 1);
    chk("fault_eject_req", int'(req0), 0);
    chk("fault_busy", int'(busy0), 0);
    chk("fault_tubes", int'({iq0, id0, in0}), inv3(11, 12, 14));
    chk("fault_remaining", int'(rem0), 25);

    pay(0, 5, 1'b0);
    @(posedge clk);
    #1 refill0 = 1'b1;
    @(posedge clk);
    #1 refill0 = 1'b0;
    idle(5);
    chk("fault_hold", int'(fault0), 1);
    chk("fault_ignore_busy", int'(busy0), 0);
    chk("fault_ignore_tubes", int'({iq0, id0, in0}), inv3(11, 12, 14));

    do_reset();
    @(negedge clk);
    chk("fault_cleared", int'(fault0), 0);
    chk("reset_tubes", int'({iq0, id0, in0}), inv3(8, 8, 8));

    push(0, KEject, 3, 0, 0, 0, -1);
    pay(0, 40, 1'b0);
    w = 0;
    while (!req0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("eject_seen", int'(req0), 1);
    idle(3);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_eject_req", int'(req0), 0);
    chk("midrst_eject_sel", int'(sel0), 0);
    chk("midrst_busy", int'(busy0), 0);
    chk("midrst_remaining", int'(rem0), 0);
    chk("midrst_tubes", int'({iq0, id0, in0}), inv3(8, 8, 8));

    ack_en[0] = 1'b1;
    push(0, KEject, 2, 0, 0, 0, -1);
    push(0, KDone, 0, 0, 0, inv3(8, 7, 8), -1);
    pay(0, 10, 1'b0);
    wait_idle(0, 30);
    idle(4);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser_ctrl.md
CHANGE_DISPENSER_CTRL -- requirements
Module: change_dispenser_ctrl

Interface
REQ-001 Parameter INV_INIT, default 8, coin count per tube loaded at reset (0..15).
REQ-002 Parameter ACK_TIMEOUT, default 15, max cycles eject_req may wait for eject_ack (1..255).
REQ-003 clk  in  1  single clock, all logic on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request to pay out change_amt; sampled only in IDLE.
REQ-006 change_amt  in  7  change owed in cents.
REQ-007 refill  in  1  reload all tubes to 15; sampled only in IDLE.
REQ-008 eject_req  out  1  coin ejector request, held until acknowledged.
REQ-009 eject_sel  out  2  coin to eject: 01 nickel, 10 dime, 11 quarter, 00 when eject_req=0.
REQ-010 eject_ack  in  1  ejector has dropped the selected coin.
REQ-011 busy  out  1  high in every state except IDLE and FAULT.
REQ-012 done  out  1  one-cycle pulse at end of a payout (complete or short).
REQ-013 short  out  1  last payout ended with remaining>0; held until next accepted start.
REQ-014 err  out  1  one-cycle pulse when start carries an invalid amount.
REQ-015 fault  out  1  ejector timeout; held until rst.
REQ-016 remaining  out  7  cents still owed in the current/last payout.
REQ-017 inv_q, inv_d, inv_n  out  4 each  quarter/dime/nickel tube counts.

Function
REQ-018 States SHALL be IDLE, SELECT, EJECT, GAP, DONE, FAULT.
REQ-019 IDLE: start with change_amt a multiple of 5 and <=95 latches remaining=change_amt, clears short, goes SELECT; otherwise err pulses next cycle, state stays IDLE.
REQ-020 IDLE: start and refill in the same cycle -> start wins, refill ignored; refill alone sets inv_q/inv_d/inv_n to 15 next cycle.
REQ-021 SELECT (one cycle): remaining=0 -> DONE; else pick largest coin with value<=remaining and count>0 (greedy Q, D, N) -> EJECT; no coin fits -> short=1, DONE.
REQ-022 EJECT: eject_req=1 and eject_sel stable for the whole state; first eject_req cycle is start cycle +2.
REQ-023 Cycle with eject_ack=1 in EJECT: decrement the selected tube and remaining by coin value (25/10/5), next state GAP; eject_ack outside EJECT ignored.
REQ-024 GAP: eject_req=0 for exactly one cycle, then SELECT.
REQ-025 Timeout counter resets on EJECT entry; ACK_TIMEOUT cycles in EJECT without ack -> FAULT, eject_req=0, no counts changed.
REQ-026 FAULT: all inputs except rst ignored; fault=1, busy=0.
REQ-027 DONE: done=1 for one cycle, then IDLE; start/refill during any non-IDLE state ignored.
REQ-028 Counts never underflow (a coin with count 0 is never selected); arithmetic on 7-bit remaining never wraps because value<=remaining.

Reset
REQ-029 rst (any state, including mid-EJECT) -> next cycle: IDLE, eject_req=0, eject_sel=00, busy=0, done=0, short=0, err=0, fault=0, remaining=0, all tubes=INV_INIT.

Structure
REQ-030 Package vend_pkg SHALL hold coin values (5/10/25), eject_sel encodings, and the state enumeration, shared with the vending FSM.
REQ-031 Sub-module coin_inventory SHALL hold the three 4-bit tube counters (reset load, refill, single decrement by select).

Verification
REQ-032 refill, start amt=40 -> ejects Q, D, N in order, each with GAP, done pulse, remaining=0, short=0, tubes 14/14/14.
REQ-033 start amt=0 -> no eject_req, done at start cycle +2, short=0.
REQ-034 INV_INIT=1, start amt=60 -> Q, D, N ejected, short=1, remaining=20, tubes 0/0/0.
REQ-035 start amt=37 and amt=100 -> err pulse each, no eject_req, state IDLE.
REQ-036 ACK_TIMEOUT=15, start amt=25, ack withheld -> FAULT after 15 EJECT cycles, eject_req=0, later start ignored until rst.
REQ-037 rst asserted during EJECT -> next cycle eject_req=0, busy=0, tubes=INV_INIT.
